// File: rtl/miriscv_timer.sv
// rtl/miriscv_timer.sv - memory-mapped down-counting timer with prescaler and level interrupt
// Define MIRISCV_TIMER_ONESHOT_EN to build the CTRL.AUTO bit and the one-shot HALT state.
module miriscv_timer #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dev_sel_i,
  input  logic        dev_we_i,
  input  logic [3:0]  dev_mask_i,
  input  logic [31:0] dev_addr_i,
  input  logic [31:0] dev_wr_data_i,
  input  logic        int_rst_i,
  output logic [31:0] dev_data_o,
  output logic        tmr_int_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pend_q, pend_d;
  logic               int_q, int_d;

  logic               auto_en;
  logic               auto_rd;
  logic               en;
  logic               wr, wr_ctrl, wr_load, wr_count, wr_status;
  logic               tick, expire;
  logic [31:0]        ctrl_rd, ctrl_wr;
  logic               unused_addr;

`ifdef MIRISCV_TIMER_ONESHOT_EN
  logic auto_q, auto_d;
  assign auto_en = auto_q;
  assign auto_rd = auto_q;
`else
  assign auto_en = 1'b1;
  assign auto_rd = 1'b0;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  // EN is the software view of "not idle"; HALT keeps it reading 1.
  assign en          = (state_q != ST_IDLE);
  assign ctrl_rd     = (32'(presc_q) << 8) | {29'd0, ie_q, auto_rd, en};
  assign unused_addr = ^{dev_addr_i[31:4], dev_addr_i[1:0]};

  always_comb begin
    wr        = dev_sel_i & dev_we_i;
    wr_ctrl   = wr & (dev_addr_i[3:2] == 2'd0);
    wr_load   = wr & (dev_addr_i[3:2] == 2'd1);
    wr_count  = wr & (dev_addr_i[3:2] == 2'd2);
    wr_status = wr & (dev_addr_i[3:2] == 2'd3);
    ctrl_wr   = merge_bytes(ctrl_rd, dev_wr_data_i, dev_mask_i);
    tick      = (state_q == ST_RUN) && (pcnt_q == presc_q);
    expire    = tick && (count_q == '0);

    state_d = state_q;
    ie_d    = ie_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    load_d  = load_q;
    count_d = count_q;
    pend_d  = pend_q;
`ifdef MIRISCV_TIMER_ONESHOT_EN
    auto_d  = auto_q;
`endif

    if (state_q == ST_RUN)
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    if (tick)
      count_d = (count_q != '0) ? count_q - 1'b1 : (auto_en ? load_q : count_q);

    if (wr_ctrl) begin
      ie_d    = ctrl_wr[2];
      presc_d = ctrl_wr[8 +: PRESC_W];
`ifdef MIRISCV_TIMER_ONESHOT_EN
      auto_d  = ctrl_wr[1];
`endif
      if (presc_d != presc_q)
        pcnt_d = '0;
    end
    if (wr_load)
      load_d = CNT_W'(merge_bytes(32'(load_q), dev_wr_data_i, dev_mask_i));
    // A software COUNT write overrides the decrement/reload of the same cycle.
    if (wr_count)
      count_d = CNT_W'(merge_bytes(32'(count_q), dev_wr_data_i, dev_mask_i));

    if (int_rst_i || (wr_status && dev_mask_i[0] && dev_wr_data_i[0]))
      pend_d = 1'b0;
    if (expire)
      pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && ctrl_wr[0]) begin
          state_d = ST_RUN;
          pcnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (wr_ctrl && !ctrl_wr[0])
          state_d = ST_IDLE;
`ifdef MIRISCV_TIMER_ONESHOT_EN
        else if (expire && !auto_en)
          state_d = ST_HALT;
`endif
      end
`ifdef MIRISCV_TIMER_ONESHOT_EN
      ST_HALT: begin
        if (wr_ctrl && !ctrl_wr[0])
          state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    int_d = pend_d & ie_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ie_q    <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
`ifdef MIRISCV_TIMER_ONESHOT_EN
      auto_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
`ifdef MIRISCV_TIMER_ONESHOT_EN
      auto_q  <= auto_d;
`endif
    end
  end

  assign tmr_int_o = int_q;

  always_comb begin
    case (dev_addr_i[3:2])
      2'd0:    dev_data_o = ctrl_rd;
      2'd1:    dev_data_o = 32'(load_q);
      2'd2:    dev_data_o = 32'(count_q);
      default: dev_data_o = {31'd0, pend_q};
    endcase
  end

endmodule

// File: tb/tb_miriscv_timer.sv
// tb/tb_miriscv_timer.sv - randomized self-checking bench for miriscv_timer
// Compares every cycle against a register-level behavioural model of the timer.
module tb_miriscv_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_sel_i;
  logic        dev_we_i;
  logic [3:0]  dev_mask_i;
  logic [31:0] dev_addr_i;
  logic [31:0] dev_wr_data_i;
  logic        int_rst_i;
  logic [31:0] dev_data_o;
  logic        tmr_int_o;

  int n_tests = 0;
  int n_fail  = 0;

  string reg_name [4] = '{"ctrl", "load", "count", "status"};

  // model state: software-visible registers plus prescaler position
  bit          m_on, m_stopped, m_auto, m_ie, m_pend;
  logic [7:0]  m_presc, m_pcnt;
  logic [31:0] m_load, m_count;

  miriscv_timer dut (
    .clk           (clk),
    .reset         (reset),
    .dev_sel_i     (dev_sel_i),
    .dev_we_i      (dev_we_i),
    .dev_mask_i    (dev_mask_i),
    .dev_addr_i    (dev_addr_i),
    .dev_wr_data_i (dev_wr_data_i),
    .int_rst_i     (int_rst_i),
    .dev_data_o    (dev_data_o),
    .tmr_int_o     (tmr_int_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  function automatic bit auto_vis();
`ifdef MIRISCV_TIMER_ONESHOT_EN
    return m_auto;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return {16'h0, m_presc, 5'b0, m_ie, auto_vis(), m_on};
      1:       return m_load;
      2:       return m_count;
      default: return {31'd0, m_pend};
    endcase
  endfunction

  task automatic model_reset();
    m_on = 0; m_stopped = 0; m_ie = 0; m_pend = 0;
    m_presc = 0; m_pcnt = 0; m_load = 0; m_count = 0;
`ifdef MIRISCV_TIMER_ONESHOT_EN
    m_auto = 0;
`else
    m_auto = 1;
`endif
  endtask

  task automatic model_step(input bit wr, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] d, input bit irq);
    bit          running, tick, fire;
    logic [31:0] ctrl_old, count_old, load_old, v;
    running   = m_on && !m_stopped;
    tick      = running && (m_pcnt == m_presc);
    fire      = tick && (m_count == 0);
    ctrl_old  = model_read(0);
    count_old = m_count;
    load_old  = m_load;

    if (running) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
    if (tick) begin
      if (count_old != 0) m_count = count_old - 1;
      else if (m_auto)    m_count = load_old;
    end
    if (fire && !m_auto) m_stopped = 1;
    if (irq || (wr && a[3:2] == 2'd3 && m[0] && d[0])) m_pend = 0;
    if (fire) m_pend = 1;

    if (wr) begin
      case (a[3:2])
        2'd0: begin
          v = lanes(ctrl_old, d, m);
          if (v[15:8] != m_presc) m_pcnt = 0;
          if (v[0] && !m_on)      m_pcnt = 0;
          if (!v[0])              m_stopped = 0;
          m_on    = v[0];
          m_ie    = v[2];
          m_presc = v[15:8];
`ifdef MIRISCV_TIMER_ONESHOT_EN
          m_auto  = v[1];
`endif
        end
        2'd1:    m_load  = lanes(load_old, d, m);
        2'd2:    m_count = lanes(count_old, d, m);
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of bus activity, then compare interrupt and all four registers.
  task automatic do_cycle(input logic s, input logic w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d, input logic irq);
    dev_sel_i     = s;
    dev_we_i      = w;
    dev_mask_i    = m;
    dev_addr_i    = a;
    dev_wr_data_i = d;
    int_rst_i     = irq;
    model_step(s & w, m, a, d, irq);
    @(posedge clk);
    @(negedge clk);
    dev_sel_i = 1'b0;
    dev_we_i  = 1'b0;
    int_rst_i = 1'b0;
    check("tmr_int", {31'd0, tmr_int_o}, {31'd0, m_pend & m_ie});
    for (int i = 0; i < 4; i++) begin
      dev_addr_i = 32'(i) << 2;
      #1;
      check(reg_name[i], dev_data_o, model_read(i));
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    do_cycle(1'b1, 1'b1, 4'hF, {28'd0, a, 2'b00}, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    dev_addr_i = {28'd0, a, 2'b00};
    #1;
    v = dev_data_o;
  endtask

  logic [31:0] v, rd_d, rd_a;
  logic [3:0]  rd_m;
  logic        rd_s, rd_w, rd_irq, irq_next, prev_int;
  int          last_rise, rises;

  initial begin
    reset = 1'b1; dev_sel_i = 0; dev_we_i = 0; dev_mask_i = 0;
    dev_addr_i = 0; dev_wr_data_i = 0; int_rst_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check({"reset_", reg_name[i]}, v, 32'd0);
    end
    check("reset_int", {31'd0, tmr_int_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // byte-lane masked COUNT write
    wr_reg(2'd2, 32'h11223344);
    do_cycle(1'b1, 1'b1, 4'b0010, 32'h8, 32'hAABBCCDD, 1'b0);
    rd(2'd2, v);
    check("byte_mask", v, 32'h1122CC44);

    // LOAD=0, PRESC=0: expiry every cycle; IE gating and collisions
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd0, 32'h001);
    idle(1);
    check("ie_gate_off", {31'd0, tmr_int_o}, 32'd0);
    wr_reg(2'd0, 32'h005);
    check("ie_gate_on", {31'd0, tmr_int_o}, 32'd1);
    do_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
    rd(2'd3, v);
    check("pend_beats_irq", v, 32'd1);
    wr_reg(2'd1, 32'h20);
    wr_reg(2'd2, 32'h10);
    rd(2'd2, v);
    check("count_wr_wins", v, 32'h10);
    idle(1);
    rd(2'd2, v);
    check("count_dec_after", v, 32'h0F);
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd3, 32'd1);
    rd(2'd3, v);
    check("w1c_status", v, 32'd0);

    // periodic: LOAD=3, PRESC=1 -> expiry every 8 cycles
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd1, 32'd3);
    wr_reg(2'd0, 32'h105);
    last_rise = -1; rises = 0; irq_next = 0; prev_int = 0;
    for (int c = 0; c < 60; c++) begin
      do_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, irq_next);
      if (irq_next) check("irq_clears", {31'd0, tmr_int_o}, 32'd0);
      if (tmr_int_o && !prev_int) begin
        if (last_rise >= 0) check("period", 32'(c - last_rise), 32'd8);
        last_rise = c;
        rises++;
      end
      prev_int = tmr_int_o;
      irq_next = tmr_int_o;
    end
    check("period_rises", {31'd0, rises >= 6}, 32'd1);
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd3, 32'd1);

`ifdef MIRISCV_TIMER_ONESHOT_EN
    wr_reg(2'd1, 32'd2);
    wr_reg(2'd2, 32'd2);
    wr_reg(2'd0, 32'h005);
    idle(3);
    rd(2'd3, v);
    check("oneshot_pend", v, 32'd1);
    idle(5);
    rd(2'd2, v);
    check("oneshot_count", v, 32'd0);
    rd(2'd0, v);
    check("oneshot_en_reads1", v, 32'h005);
    wr_reg(2'd3, 32'd1);
    idle(10);
    rd(2'd3, v);
    check("oneshot_no_repend", v, 32'd0);
    wr_reg(2'd0, 32'd0);
`else
    wr_reg(2'd0, 32'h007);
    rd(2'd0, v);
    check("auto_reads0", v, 32'h005);
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd3, 32'd1);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rd_s   = ($urandom_range(0, 99) < 40);
      rd_w   = ($urandom_range(0, 99) < 80);
      rd_a   = $urandom();
      rd_m   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rd_m = 4'hF;
      rd_d   = $urandom();
      case (rd_a[3:2])
        2'd0: begin
          rd_d[15:8] = 8'($urandom_range(0, 3));
          rd_d[0]    = ($urandom_range(0, 9) != 0);
        end
        2'd1, 2'd2: if ($urandom_range(0, 3) != 0) rd_d = $urandom_range(0, 9);
        default: ;
      endcase
      rd_irq = ($urandom_range(0, 9) == 0);
      do_cycle(rd_s, rd_w, rd_m, rd_a, rd_d, rd_irq);
    end

    // asynchronous reset in the middle of a run
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd2, 32'd5);
    wr_reg(2'd0, 32'h0000FF05);
    idle(3);
    rd(2'd2, v);
    check("pre_reset_count", v, 32'd5);
    reset = 1'b1;
    rd(2'd2, v);
    check("async_rst_count", v, 32'd0);
    rd(2'd0, v);
    check("async_rst_ctrl", v, 32'd0);
    check("async_rst_int", {31'd0, tmr_int_o}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
